// File: rtl/wb_commit_buffer_if.sv
// Bundles the allocation, writeback and commit/RVFI signals of wb_commit_buffer.
// master = front end / execution side, slave = the commit buffer itself.
interface wb_commit_buffer_if #(
    parameter int NUM_CH   = 2,
    parameter int DEPTH    = 8,
    parameter int COMMIT_W = 2,
    parameter int ORDER_W  = 64
);
    localparam int IDX_W = $clog2(DEPTH);

    logic                        alloc_valid;
    logic                        alloc_ready;
    logic [IDX_W-1:0]            alloc_seq;
    logic [NUM_CH-1:0]           wb_valid;
    logic [NUM_CH*IDX_W-1:0]     wb_seq;
    logic [NUM_CH-1:0]           wb_we;
    logic [NUM_CH*5-1:0]         wb_rd;
    logic [NUM_CH*32-1:0]        wb_data;
    logic [NUM_CH*32-1:0]        wb_inst;
    logic [NUM_CH*32-1:0]        wb_pc;
    logic [NUM_CH*32-1:0]        wb_pc_next;
    logic                        flush;
    logic [IDX_W:0]              count;
    logic [COMMIT_W-1:0]         regf_we;
    logic [COMMIT_W*5-1:0]       rd_s;
    logic [COMMIT_W*32-1:0]      rd_v;
    logic [COMMIT_W-1:0]         rvfi_valid;
    logic [COMMIT_W*ORDER_W-1:0] rvfi_order;
    logic [COMMIT_W*32-1:0]      rvfi_inst;
    logic [COMMIT_W*32-1:0]      rvfi_pc_rdata;
    logic [COMMIT_W*32-1:0]      rvfi_pc_wdata;
    logic [COMMIT_W*32-1:0]      rvfi_rd_wdata;
    logic [COMMIT_W*5-1:0]       rvfi_rd_addr;

    modport master (
        output alloc_valid, wb_valid, wb_seq, wb_we, wb_rd, wb_data, wb_inst, wb_pc, wb_pc_next, flush,
        input  alloc_ready, alloc_seq, count, regf_we, rd_s, rd_v, rvfi_valid, rvfi_order,
               rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rd_wdata, rvfi_rd_addr
    );

    modport slave (
        input  alloc_valid, wb_valid, wb_seq, wb_we, wb_rd, wb_data, wb_inst, wb_pc, wb_pc_next, flush,
        output alloc_ready, alloc_seq, count, regf_we, rd_s, rd_v, rvfi_valid, rvfi_order,
               rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rd_wdata, rvfi_rd_addr
    );
endinterface

// File: rtl/wb_commit_buffer.sv
// In-order commit buffer: out-of-order writeback in, up to COMMIT_W program-order retires out per cycle.
// Latency: writeback edge E0 sets done, retire outputs registered at E0+1; alloc_ready updates 1 edge after alloc.
// Backpressure: alloc_ready drops when DEPTH entries are in flight; writeback and commit are never stalled.
module wb_commit_buffer #(
    parameter int NUM_CH   = 2,
    parameter int DEPTH    = 8,
    parameter int COMMIT_W = 2,
    parameter int ORDER_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    wb_commit_buffer_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_next;
    } entry_t;

    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0]   alloc_q, alloc_d, done_q, done_d;
    entry_t             ent_q [DEPTH];
    entry_t             ent_d [DEPTH];
    logic [ORDER_W-1:0] order_q, order_d;

    logic [COMMIT_W-1:0]              rvfi_valid_q, rvfi_valid_d;
    logic [COMMIT_W-1:0]              regf_we_q, regf_we_d;
    logic [COMMIT_W-1:0][4:0]         slot_rd_q, slot_rd_d;
    logic [COMMIT_W-1:0][31:0]        slot_wdata_q, slot_wdata_d;
    logic [COMMIT_W-1:0][31:0]        slot_inst_q, slot_inst_d;
    logic [COMMIT_W-1:0][31:0]        slot_pc_q, slot_pc_d;
    logic [COMMIT_W-1:0][31:0]        slot_pcn_q, slot_pcn_d;
    logic [COMMIT_W-1:0][ORDER_W-1:0] slot_order_q, slot_order_d;

    logic [PTR_W-1:0] count;
    logic             alloc_ready;
    logic             alloc_fire;
    logic [IDX_W-1:0] tail_idx;
    logic [IDX_W-1:0] wb_idx   [NUM_CH];
    logic [IDX_W-1:0] slot_idx [COMMIT_W];
    logic [PTR_W-1:0] n_ret;
    logic             run;

    // Wrap bit in the pointer MSB makes tail-head the exact occupancy, including full.
    assign count       = tail_q - head_q;
    assign alloc_ready = (count < PTR_W'(DEPTH));
    assign alloc_fire  = bus.alloc_valid && alloc_ready;
    assign tail_idx    = tail_q[IDX_W-1:0];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_wb_idx
        assign wb_idx[c] = bus.wb_seq[c*IDX_W +: IDX_W];
    end

    for (genvar k = 0; k < COMMIT_W; k++) begin : g_slot_idx
        assign slot_idx[k] = head_q[IDX_W-1:0] + IDX_W'(k);
    end

    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        alloc_d      = alloc_q;
        done_d       = done_q;
        ent_d        = ent_q;
        order_d      = order_q;
        rvfi_valid_d = '0;
        regf_we_d    = '0;
        slot_rd_d    = '0;
        slot_wdata_d = '0;
        slot_inst_d  = '0;
        slot_pc_d    = '0;
        slot_pcn_d   = '0;
        slot_order_d = '0;
        n_ret        = '0;
        run          = 1'b1;

        // Checking done_d lets the lowest channel claim an entry when two channels collide.
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.wb_valid[c] && alloc_q[wb_idx[c]] && !done_d[wb_idx[c]]) begin
                done_d[wb_idx[c]]      = 1'b1;
                ent_d[wb_idx[c]].we      = bus.wb_we[c];
                ent_d[wb_idx[c]].rd      = bus.wb_rd[c*5 +: 5];
                ent_d[wb_idx[c]].data    = bus.wb_data[c*32 +: 32];
                ent_d[wb_idx[c]].inst    = bus.wb_inst[c*32 +: 32];
                ent_d[wb_idx[c]].pc      = bus.wb_pc[c*32 +: 32];
                ent_d[wb_idx[c]].pc_next = bus.wb_pc_next[c*32 +: 32];
            end
        end

        for (int k = 0; k < COMMIT_W; k++) begin
            if (run && alloc_q[slot_idx[k]] && done_q[slot_idx[k]]) begin
                rvfi_valid_d[k] = 1'b1;
                slot_order_d[k] = order_q + ORDER_W'(k);
                slot_rd_d[k]    = ent_q[slot_idx[k]].we ? ent_q[slot_idx[k]].rd : 5'd0;
                regf_we_d[k]    = ent_q[slot_idx[k]].we && (ent_q[slot_idx[k]].rd != 5'd0);
                slot_wdata_d[k] = (slot_rd_d[k] != 5'd0) ? ent_q[slot_idx[k]].data : 32'd0;
                slot_inst_d[k]  = ent_q[slot_idx[k]].inst;
                slot_pc_d[k]    = ent_q[slot_idx[k]].pc;
                slot_pcn_d[k]   = ent_q[slot_idx[k]].pc_next;
                alloc_d[slot_idx[k]] = 1'b0;
                done_d[slot_idx[k]]  = 1'b0;
                n_ret = n_ret + PTR_W'(1);
            end else begin
                run = 1'b0;
            end
        end
        head_d  = head_q + n_ret;
        order_d = order_q + ORDER_W'(n_ret);

        if (alloc_fire) begin
            alloc_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = 1'b0;
            tail_d            = tail_q + PTR_W'(1);
        end

        if (bus.flush) begin
            head_d       = head_q;
            tail_d       = head_q;
            order_d      = order_q;
            alloc_d      = '0;
            done_d       = '0;
            rvfi_valid_d = '0;
            regf_we_d    = '0;
            slot_rd_d    = '0;
            slot_wdata_d = '0;
            slot_inst_d  = '0;
            slot_pc_d    = '0;
            slot_pcn_d   = '0;
            slot_order_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            alloc_q      <= '0;
            done_q       <= '0;
            ent_q        <= '{default: '0};
            order_q      <= '0;
            rvfi_valid_q <= '0;
            regf_we_q    <= '0;
            slot_rd_q    <= '0;
            slot_wdata_q <= '0;
            slot_inst_q  <= '0;
            slot_pc_q    <= '0;
            slot_pcn_q   <= '0;
            slot_order_q <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            alloc_q      <= alloc_d;
            done_q       <= done_d;
            ent_q        <= ent_d;
            order_q      <= order_d;
            rvfi_valid_q <= rvfi_valid_d;
            regf_we_q    <= regf_we_d;
            slot_rd_q    <= slot_rd_d;
            slot_wdata_q <= slot_wdata_d;
            slot_inst_q  <= slot_inst_d;
            slot_pc_q    <= slot_pc_d;
            slot_pcn_q   <= slot_pcn_d;
            slot_order_q <= slot_order_d;
        end
    end

    // A completion must target an in-flight entry that has not completed yet.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.wb_valid[c]) begin
                    assert (alloc_q[wb_idx[c]] && !done_q[wb_idx[c]]);
                end
            end
        end
    end

    assign bus.alloc_ready   = alloc_ready;
    assign bus.alloc_seq     = tail_idx;
    assign bus.count         = count;
    assign bus.regf_we       = regf_we_q;
    assign bus.rd_s          = slot_rd_q;
    assign bus.rd_v          = slot_wdata_q;
    assign bus.rvfi_valid    = rvfi_valid_q;
    assign bus.rvfi_order    = slot_order_q;
    assign bus.rvfi_inst     = slot_inst_q;
    assign bus.rvfi_pc_rdata = slot_pc_q;
    assign bus.rvfi_pc_wdata = slot_pcn_q;
    assign bus.rvfi_rd_wdata = slot_wdata_q;
    assign bus.rvfi_rd_addr  = slot_rd_q;
endmodule
